// File: rtl/des_decrypt_iter_if.sv
// Handshake bus for the iterative DES decryption core: cipher/key in, plaintext out.
// Vectors are numbered [64:1] so that index 64 is DES bit 1.
interface des_decrypt_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [64:1] cipher;
  logic [64:1] key;
  logic        out_valid;
  logic        out_ready;
  logic [64:1] decrypt;
  logic        busy;

  modport master (
    output in_valid, cipher, key, out_ready,
    input  in_ready, out_valid, decrypt, busy
  );

  modport slave (
    input  in_valid, cipher, key, out_ready,
    output in_ready, out_valid, decrypt, busy
  );
endinterface

// File: rtl/des_decrypt_iter.sv
// Round-serial DES decryption: one Feistel round per clock.
// Subkeys K16..K1 come from right-rotating C/D starting at C0/D0.
module des_decrypt_iter (
  input  logic             clk,
  input  logic             reset,
  des_decrypt_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int unsigned LAST_ROUND = 16;

  // Permutation tables: one byte per output bit, first entry in the MSBs, DES 1-based numbering.
  localparam logic [511:0] IP_T = {
    8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
    8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
    8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
    8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
    8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
    8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7};
  localparam logic [511:0] FP_T = {
    8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32,
    8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
    8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,
    8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
    8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28,
    8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
    8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26,
    8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25};
  localparam logic [383:0] E_T = {
    8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,  8'd4,  8'd5,  8'd6,  8'd7,  8'd8,  8'd9,
    8'd8,  8'd9,  8'd10, 8'd11, 8'd12, 8'd13, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
    8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25,
    8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1};
  localparam logic [255:0] P_T = {
    8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17,
    8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
    8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,
    8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25};
  localparam logic [447:0] PC1_T = {
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
    8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
    8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
    8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
    8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4};
  localparam logic [383:0] PC2_T = {
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32};
  // S1..S8, four rows each, one nibble per column.
  localparam logic [2047:0] S_T = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  // Generic bit permutation; operands and result are right-aligned in 64 bits.
  function automatic logic [63:0] permute(input logic [63:0] x, input logic [511:0] tbl,
                                          input int unsigned n_in, input int unsigned n_out);
    logic [63:0] y;
    y = '0;
    for (int unsigned j = 0; j < 64; j++)
      if (j < n_out)
        y[6'(n_out - 1 - j)] = x[6'(n_in - 32'(tbl[9'(8 * (n_out - 1 - j)) +: 8]))];
    return y;
  endfunction

  function automatic logic [31:0] sbox(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  six;
    logic [8:0]  idx;
    y = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[6'(42 - 6 * b) +: 6];
      idx = {3'(b), six[5], six[0], six[4:1]};
      y[5'(28 - 4 * b) +: 4] = S_T[11'(4 * (511 - 32'(idx))) +: 4];
    end
    return y;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [4:0]  cnt_q;
  logic [63:0] dec_q;
  logic        in_ready_q, out_valid_q, busy_q;
  logic        in_ready_d, out_valid_d, busy_d;
  logic        accept, last;
  logic [27:0] c_rot, d_rot;
  logic [47:0] subkey, e_r;
  logic [31:0] s_out, f_out;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign last   = (cnt_q == 5'(LAST_ROUND));

  // Reverse key schedule: right-rotate by 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  always_comb begin
    c_rot = c_q;
    d_rot = d_q;
    case (cnt_q)
      5'd1: ;
      5'd2, 5'd9, 5'd16: begin
        c_rot = {c_q[0], c_q[27:1]};
        d_rot = {d_q[0], d_q[27:1]};
      end
      default: begin
        c_rot = {c_q[1:0], c_q[27:2]};
        d_rot = {d_q[1:0], d_q[27:2]};
      end
    endcase
  end

  assign subkey = 48'(permute({8'd0, c_rot, d_rot}, 512'(PC2_T), 56, 48));
  assign e_r    = 48'(permute({32'd0, r_q}, 512'(E_T), 32, 48));
  assign s_out  = sbox(e_r ^ subkey);
  assign f_out  = 32'(permute({32'd0, s_out}, 512'(P_T), 32, 32));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = ROUND;
      ROUND:   if (last)         state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered alongside the state they describe.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    case (state_d)
      IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      DONE:    out_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_q   <= '0;
      r_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      dec_q <= '0;
    end else if (accept) begin
      {l_q, r_q} <= permute(bus.cipher, 512'(IP_T), 64, 64);
      {c_q, d_q} <= 56'(permute(bus.key, 512'(PC1_T), 64, 56));
      cnt_q      <= 5'd1;
    end else if (state_q == ROUND) begin
      l_q   <= r_q;
      r_q   <= l_q ^ f_out;
      c_q   <= c_rot;
      d_q   <= d_rot;
      cnt_q <= cnt_q + 5'd1;
      if (last) dec_q <= permute({l_q ^ f_out, r_q}, 512'(FP_T), 64, 64);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.decrypt   = dec_q;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Bench for des_decrypt_iter: known-answer vectors, backpressure, reset abort and
// a back-to-back run fed by a behavioural DES encryptor with a scoreboard.
module tb_des_decrypt_iter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [63:0] exp_q[$];

  des_decrypt_iter_if bus ();
  des_decrypt_iter dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1, C1 = 64'h85E813540F0AB405, P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73, C2 = 64'h0000000000000000, P2 = 64'h8787878787878787;
  localparam logic [63:0] K3 = 64'h123556789ABDDEF0;

  int ip_t [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                    64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int fp_t [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                    37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int e_t [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int p_t [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9,
                    19,13,30,6,22,11,4,25};
  int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int shift_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  logic [63:0] sb_t [8][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

  function automatic int tval(input int sel, input int j);
    case (sel)
      0:       return ip_t[j];
      1:       return fp_t[j];
      2:       return e_t[j];
      3:       return p_t[j];
      4:       return pc1_t[j];
      default: return pc2_t[j];
    endcase
  endfunction

  function automatic logic [63:0] perm(input logic [63:0] x, input int win, input int wout, input int sel);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < wout; j++) y[6'(wout - 1 - j)] = x[6'(win - tval(sel, j))];
    return y;
  endfunction

  // Forward DES: full key schedule first, then 16 rounds.
  function automatic logic [63:0] des_enc(input logic [63:0] k, input logic [63:0] m);
    logic [63:0] t;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [47:0] x;
    logic [31:0] l, r, s, tmp;
    logic [5:0]  six;
    int          row, col;
    t = perm(k, 64, 56, 4);
    c = t[55:28];
    d = t[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int n = 0; n < shift_t[i]; n++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t = perm({8'd0, c, d}, 56, 48, 5);
      ks[i] = t[47:0];
    end
    t = perm(m, 64, 64, 0);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < 16; i++) begin
      t = perm({32'd0, r}, 32, 48, 2);
      x = t[47:0] ^ ks[i];
      s = '0;
      for (int b = 0; b < 8; b++) begin
        six = x[6'(42 - 6 * b) +: 6];
        row = int'({six[5], six[0]});
        col = int'(six[4:1]);
        s = {s[27:0], sb_t[b][row][6'(60 - 4 * col) +: 4]};
      end
      t = perm({32'd0, s}, 32, 32, 3);
      tmp = r;
      r = l ^ t[31:0];
      l = tmp;
    end
    return perm({r, l}, 64, 64, 1);
  endfunction

  // Drive one block until accepted; the expected plaintext goes on the scoreboard.
  task automatic do_accept(input logic [63:0] k, input logic [63:0] c, input logic [63:0] e, output int acc);
    logic took;
    took = 1'b0;
    acc  = -1;
    bus.key = k; bus.cipher = c; bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !took; i++) begin
      took = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.key = ~k; bus.cipher = ~c;
    n_vec++;
    if (took) begin
      acc = cyc;
      exp_q.push_back(e);
    end else begin
      n_err++;
      $display("FAIL accept_timeout: in_ready never high within 40 cycles");
    end
  endtask

  task automatic wait_out(input int acc, input string name);
    logic        seen;
    logic [63:0] e;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus.out_valid === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_timeout: out_valid not seen within 60 cycles", name);
      return;
    end
    if (acc >= 0) begin
      n_vec++;
      if (cyc - acc !== 16) begin
        n_err++;
        $display("FAIL %s_latency: got %0d cycles, want 16", name, cyc - acc);
      end
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_scoreboard: output %h with no expected entry", name, bus.decrypt);
    end else begin
      e = exp_q.pop_front();
      if (bus.decrypt !== e) begin
        n_err++;
        $display("FAIL %s_data: got %h want %h", name, bus.decrypt, e);
      end
    end
    if (bus.out_ready === 1'b1) begin
      @(posedge clk); #1;
      n_vec++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL %s_handshake: out_valid=%b in_ready=%b want 0/1", name, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.cipher = '0; bus.key = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec += 4;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.decrypt !== 64'h0) begin n_err++; $display("FAIL reset_decrypt: got %h want 0", bus.decrypt); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vector(input string name, input logic [63:0] k, input logic [63:0] c, input logic [63:0] p);
    int acc;
    bus.out_ready = 1'b1;
    do_accept(k, c, p, acc);
    n_vec++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s_running: busy=%b in_ready=%b want 1/0", name, bus.busy, bus.in_ready);
    end
    wait_out(acc, name);
  endtask

  task automatic test_backpressure();
    int   acc;
    logic bad;
    bus.out_ready = 1'b0;
    do_accept(K1, C1, P1, acc);
    wait_out(acc, "bp");
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'(i % 2);
      bus.cipher = {$urandom, $urandom};
      @(posedge clk); #1;
      n_vec++;
      if (bus.decrypt !== P1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold: cycle %0d decrypt=%h out_valid=%b in_ready=%b want %h/1/0",
                 i, bus.decrypt, bus.out_valid, bus.in_ready, P1);
      end
    end
    // Output handshake and a pending input on the same edge: only the handshake happens.
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.decrypt !== P1) begin
      n_err++;
      $display("FAIL bp_after: busy=%b decrypt=%h want 0/%h", bus.busy, bus.decrypt, P1);
    end
  endtask

  task automatic test_reset_mid();
    int   acc;
    logic bad;
    bus.out_ready = 1'b1;
    do_accept(K2, C2, P2, acc);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    exp_q.delete();
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.decrypt !== 64'h0) begin
      n_err++;
      $display("FAIL midreset_values: in_ready=%b out_valid=%b busy=%b decrypt=%h want 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.decrypt);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin n_err++; $display("FAIL midreset_abort: out_valid rose for aborted block, want 0"); end
    // Reset again with a block already waiting; it must be taken on the first edge after release.
    reset = 1'b0;
    bus.key = K1; bus.cipher = C1; bus.in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_first_accept: busy=%b in_ready=%b want 1/0", bus.busy, bus.in_ready);
    end
    exp_q.push_back(P1);
    acc = cyc;
    wait_out(acc, "after_reset");
  endtask

  task automatic test_back_to_back();
    int          acc, prev;
    logic [63:0] k, m, c;
    bus.out_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < 50; i++) begin
      k = {$urandom, $urandom};
      m = {$urandom, $urandom};
      c = des_enc(k, m);
      do_accept(k, c, m, acc);
      if (prev >= 0) begin
        n_vec++;
        if (acc - prev !== 18) begin
          n_err++;
          $display("FAIL b2b_cadence: block %0d spacing %0d cycles, want 18", i, acc - prev);
        end
      end
      prev = acc;
      wait_out(acc, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_vector("basic", K1, C1, P1);
    test_vector("second", K2, C2, P2);
    test_vector("parity", K3, C1, P1);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/des_decrypt_iter.md
# des_decrypt_iter

Iterative, round-serial DES decryption core. It takes one 64-bit ciphertext block and one 64-bit key through a valid/ready input handshake. It runs the 16 Feistel rounds one per clock, applying the subkeys in reverse order (K16 down to K1). It then presents the 64-bit plaintext through a valid/ready output handshake. It is the decrypt-side counterpart of the encryption DUT, fed from the same cipher/key bus and driving the `decrypt` bus that the verification environment compares against the original `msg`.

## Interface
Parameters:
- none. Function is fixed to single DES with 16 rounds.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting low clears state immediately; release is sampled on `clk`.
- `in_valid`  in  1  source has a valid `cipher`/`key` pair.
- `in_ready`  out  1  core can accept a block; high only in IDLE.
- `cipher`  in  64 [64:1]  ciphertext. Bit 64 is DES bit 1 (MSB).
- `key`  in  64 [64:1]  DES key, same bit order. Parity bits (DES bits 8,16,…,64) are ignored.
- `out_valid`  out  1  `decrypt` holds a finished plaintext.
- `out_ready`  in  1  sink accepts the plaintext.
- `decrypt`  out  64 [64:1]  plaintext, same bit order.
- `busy`  out  1  high in ROUND or DONE.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`:
    - L/R ← IP(`cipher`).
    - C/D ← PC1(`key`).
    - round counter ← 1.
    - go to ROUND.
- ROUND, one round per cycle, counter i = 1..16:
  - Rotate C,D right by R(i) = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. This yields C(17-i), D(17-i).
  - Subkey = PC2(rotated C,D) = K(17-i).
  - Update: L ← R, R ← L ^ f(R, subkey).
  - f = P(S1..S8(E(R) ^ subkey)).
  - After i=16:
    - `decrypt` ← FP(R‖L), with the final swap included.
    - `out_valid` ← 1.
    - go to DONE.
- DONE:
  - Hold `decrypt` and `out_valid`=1 until `out_ready`=1.
  - On that handshake edge: `out_valid` ← 0, go to IDLE.
- `in_valid` outside IDLE is ignored. The source must hold `cipher`/`key` stable only until its handshake. The inputs are captured, so later changes have no effect.
- `decrypt` keeps its last value after the output handshake. It changes only at the end of the next block's round 16.
- S-boxes, E, P, IP, FP, PC1 and PC2 follow FIPS 46-3 exactly. Ciphertext produced by the encryption DUT with the same key must decrypt to the original `msg`.

## Timing
- Reset values (while `reset`=0):
  - `in_ready`=1 (IDLE).
  - `out_valid`=0.
  - `busy`=0.
  - `decrypt`=64'h0.
  - Internal L/R/C/D/counter = 0.
- Latency:
  - Accept at edge T.
  - Rounds execute at edges T+1 … T+16.
  - `out_valid`=1 and valid `decrypt` from just after edge T+16. That is 16 cycles accept-to-valid.
- Throughput, with `out_ready` held high: output handshake at edge T+17, `in_ready` high after T+17, next accept at T+18. Minimum 18 cycles per block.
- Backpressure: with `out_ready` low, DONE is held indefinitely and `in_ready` stays 0.
- Reset mid-operation (ROUND or DONE):
  - Immediate return to IDLE with reset values.
  - The aborted block never produces `out_valid`.
  - The first accept is possible on the first edge after release with `in_valid`=1.
- `in_valid` and `out_ready` may be high simultaneously in DONE. Only the output handshake occurs; no input is accepted that cycle.
- `busy` = (state != IDLE), registered together with the state.

## Test plan
- Basic vector: `key`=64'h133457799BBCDFF1, `cipher`=64'h85E813540F0AB405 → `decrypt`=64'h0123456789ABCDEF, with `out_valid` rising exactly 16 cycles after accept.
- Second vector: `key`=64'h0E329232EA6D0D73, `cipher`=64'h0000000000000000 → `decrypt`=64'h8787878787878787.
- Parity independence: `key`=64'h123556789ABDDEF0 (parity bits flipped), `cipher`=64'h85E813540F0AB405 → `decrypt`=64'h0123456789ABCDEF.
- Backpressure:
  - Hold `out_ready`=0 for 20 cycles after `out_valid`.
  - `decrypt` is stable; `in_ready`=0; `in_valid` pulses are ignored.
  - Raise `out_ready` → one handshake, then `in_ready`=1 the next cycle.
- Reset mid-round:
  - Assert `reset`=0 at round 8.
  - Outputs go to reset values immediately; no `out_valid` follows.
  - After release, the basic vector decrypts correctly.
- Back-to-back loopback:
  - 50 random key/msg pairs encrypted by the encryption DUT are fed to this core with `out_ready`=1.
  - `decrypt`==`msg` for every block, at an 18-cycle cadence.
